mem_stage: RTL and testbench
============================

# mem_stage

Multicycle data-memory access stage of the non-pipelined RiSC-16 core, sitting directly upstream of writeback. It takes the effective address from the ALU and store data from the register file, performs a request/acknowledge transaction with an external data memory, and presents the registered load result as `data_out` to writeback's target mux. While a transaction is in flight it asserts `stall` so the PC and register-file write are held.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: REQ cycles without `dmem_ack` before a bus error (used only with `MEM_TIMEOUT_EN`).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mem_en` in 1: current instruction is LW or SW; level, held until retire.
- `mem_we` in 1: 1 = SW, 0 = LW; valid with `mem_en`.
- `addr` in `WORD_LEN`: effective address (ALU result).
- `wdata` in `WORD_LEN`: store data.
- `data_out` out `WORD_LEN`: registered load data to writeback.
- `stall` out 1: hold PC/regfile write enable.
- `done` out 1: one-cycle retire pulse for a memory instruction.
- `bus_err` out 1: one-cycle pulse on timeout; tied 0 without `MEM_TIMEOUT_EN`.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out `WORD_LEN`, `dmem_wdata` out `WORD_LEN`: request side.
- `dmem_rdata` in `WORD_LEN`, `dmem_ack` in 1: response side.

## Operation
- FSM states IDLE, REQ, DONE.
- IDLE: if `mem_en`=1 at a clock edge, latch `addr`, `wdata`, `mem_we` into request registers and go to REQ. Otherwise stay.
- REQ: `dmem_req`=1, and `dmem_we`/`dmem_addr`/`dmem_wdata` come from the latched registers, stable for the entire REQ. On an edge with `dmem_ack`=1, go to DONE. For a load, also capture `dmem_rdata` into `data_out`.
- DONE: `done`=1 and `stall`=0. Always go to IDLE next, ignoring `mem_en` (it still belongs to the retiring instruction).
- `stall` = (state==IDLE && `mem_en`) || state==REQ. This is combinational, so the first cycle is stalled.
- `dmem_ack` outside REQ is ignored.
- Stores leave `data_out` unchanged. `data_out` holds the last load value until the next load completes.
- Address is passed through unmodified (word-addressed, no increment, no wrap logic). 0xFFFF is a legal address.

## Timing
- Reset (async, `rst_n`=0): state IDLE, `data_out`=0, `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0, `done`=0, `bus_err`=0, timeout counter 0. `stall` then follows `mem_en` combinationally.
- Reset asserted mid-REQ drops `dmem_req` immediately. The transaction is abandoned and a late ack is ignored.
- `mem_en` is sampled in cycle 0. `dmem_req` is high from cycle 1. If ack arrives in cycle k≥1, DONE is in cycle k+1 and `data_out` is valid from cycle k+1.
- Minimum latency with a zero-wait memory (ack in cycle 1) is 3 cycles: IDLE, REQ, DONE.
- Back-to-back memory instructions: the next `mem_en` is accepted in the IDLE cycle after DONE.
- `dmem_req` falls on the edge after the ack-sampling edge. Memory must drop `dmem_ack` when `dmem_req` is low.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches `TIMEOUT_CYCLES`, go to DONE with `bus_err`=1 for that cycle. For a load, `data_out` is set to 0.
  - Ack and timeout on the same edge: the ack wins, with no `bus_err`.
- `MEM_TIMEOUT_EN` undefined: no counter, and REQ waits indefinitely. `bus_err` is constant 0.

## Structure
- Shared `defines.v` holds `WORD_LEN` and the state encodings `` `MEM_ST_IDLE ``, `` `MEM_ST_REQ ``, `` `MEM_ST_DONE `` (2 bits), alongside the existing `SEL_TGT_*` selects.
- One sub-module, `mem_timer`: clearable saturating cycle counter with a `expired` output. It is instantiated only under `MEM_TIMEOUT_EN`.

## Test plan
- LW: `addr`=0x0010, memory acks in the first REQ cycle with 0xBEEF -> `dmem_req` high 1 cycle, `stall` high 2 cycles, `done` pulse in cycle 2, `data_out`=0xBEEF.
- SW, 3-cycle ack delay: `addr`=0xFFFF, `wdata`=0x1234 -> `dmem_we`=1, address/data stable for 3 REQ cycles, `data_out` unchanged, `done` in cycle 4.
- Back-to-back LW then LW (0x5555, 0xAAAA) -> second request starts only after IDLE, and `data_out` updates 0x5555 then 0xAAAA.
- `rst_n` pulled low during REQ, stray ack afterwards -> all outputs go to reset values immediately, and the ack causes no `done` and no `data_out` change.
- `MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, no ack on a LW -> `bus_err` and `done` pulse after 4 REQ cycles, and `data_out`=0.
- `MEM_TIMEOUT_EN`, ack on the 4th REQ cycle -> normal completion with `bus_err`=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared word width and FSM state encodings for the RiSC-16 data-memory access stage.
package mem_stage_pkg;

  localparam int WORD_LEN = 16;

  typedef logic [WORD_LEN-1:0] word_t;

  localparam logic [1:0] MEM_ST_IDLE = 2'd0;
  localparam logic [1:0] MEM_ST_REQ  = 2'd1;
  localparam logic [1:0] MEM_ST_DONE = 2'd2;

endpackage

// File: rtl/mem_timer.sv
// Clearable saturating cycle counter; expired_o flags that the current counted cycle is the LIMIT-th one.
module mem_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // cnt_q counts completed no-ack cycles, so LAST means this cycle is the final one allowed.
  assign expired_o = (cnt_q >= LAST);

endmodule

// File: rtl/mem_stage.sv
// Multicycle data-memory access stage (IDLE -> REQ -> DONE) with a req/ack data-memory port.
// Optional bus timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_en,
  input  logic                mem_we,
  input  logic [WORD_LEN-1:0] addr,
  input  logic [WORD_LEN-1:0] wdata,
  output logic [WORD_LEN-1:0] data_out,
  output logic                stall,
  output logic                done,
  output logic                bus_err,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [WORD_LEN-1:0] dmem_addr,
  output logic [WORD_LEN-1:0] dmem_wdata,
  input  logic [WORD_LEN-1:0] dmem_rdata,
  input  logic                dmem_ack,
  output logic [1:0]          dbg_state
);

  // Handshake: dmem_req stays high with stable we/addr/wdata until an edge samples
  // dmem_ack=1; the transfer completes on that edge and req drops on the next state.
  logic [1:0] state_q, state_d;
  logic       we_q;
  word_t      addr_q, wdata_q;
  word_t      data_q, data_d;
  logic       bus_err_q, bus_err_d;
  logic       timeout;

`ifdef MEM_TIMEOUT_EN
  logic expired;

  mem_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (state_q != MEM_ST_REQ),
    .inc_i     ((state_q == MEM_ST_REQ) && !dmem_ack),
    .expired_o (expired)
  );

  assign timeout = (state_q == MEM_ST_REQ) && !dmem_ack && expired;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    bus_err_d = 1'b0;
    case (state_q)
      MEM_ST_IDLE: begin
        if (mem_en) state_d = MEM_ST_REQ;
      end
      MEM_ST_REQ: begin
        // Ack takes priority over a timeout on the same edge.
        if (dmem_ack) begin
          state_d = MEM_ST_DONE;
          if (!we_q) data_d = dmem_rdata;
        end else if (timeout) begin
          state_d   = MEM_ST_DONE;
          bus_err_d = 1'b1;
          if (!we_q) data_d = '0;
        end
      end
      MEM_ST_DONE: state_d = MEM_ST_IDLE;
      default:     state_d = MEM_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MEM_ST_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      data_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      bus_err_q <= bus_err_d;
      if ((state_q == MEM_ST_IDLE) && mem_en) begin
        we_q    <= mem_we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
    end
  end

  assign data_out   = data_q;
  assign stall      = ((state_q == MEM_ST_IDLE) && mem_en) || (state_q == MEM_ST_REQ);
  assign done       = (state_q == MEM_ST_DONE);
  assign bus_err    = bus_err_q;
  assign dmem_req   = (state_q == MEM_ST_REQ);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: scripted memory responses with an expected-data queue.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] data_out;
  logic        stall;
  logic        done;
  logic        bus_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata;
  logic        dmem_ack;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_data;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .addr       (addr),
    .wdata      (wdata),
    .data_out   (data_out),
    .stall      (stall),
    .done       (done),
    .bus_err    (bus_err),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .dbg_state  (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one memory instruction from an IDLE cycle (entered just after a rising edge).
  // ack_cyc = 0 means the memory never acks.
  task automatic do_op(input logic we, input logic [15:0] a, input logic [15:0] wd,
                       input int ack_cyc, input logic [15:0] rd, input logic exp_err);
    int n_req;
    int exp_req;
    logic [15:0] exp_data;
    mem_en = 1'b1;
    mem_we = we;
    addr   = a;
    wdata  = wd;
    if (!we) model_data = exp_err ? 16'h0000 : rd;
    exp_q.push_back(model_data);
    exp_req = (ack_cyc != 0) ? ack_cyc : TO;
    @(negedge clk);
    check("idle_stall", stall, 1);
    check("idle_req", dmem_req, 0);
    @(posedge clk); #1;
    addr  = ~a;
    wdata = ~wd;
    n_req = 0;
    while (dmem_req === 1'b1 && n_req < 64) begin
      n_req++;
      dmem_ack   = (ack_cyc != 0) && (n_req == ack_cyc);
      dmem_rdata = dmem_ack ? rd : 16'($urandom_range(0, 65535));
      @(negedge clk);
      check("req_stall", stall, 1);
      check("req_done", done, 0);
      check("req_we", dmem_we, we);
      check("req_addr", dmem_addr, a);
      check("req_wdata", dmem_wdata, wd);
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
    check("req_cycles", n_req, exp_req);
    @(negedge clk);
    check("done_pulse", done, 1);
    check("done_stall", stall, 0);
    check("done_req", dmem_req, 0);
    check("done_bus_err", bus_err, exp_err);
    if (exp_q.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      exp_data = exp_q.pop_front();
      check("data_out", data_out, exp_data);
    end
    @(posedge clk); #1;
    mem_en = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    addr       = '0;
    wdata      = '0;
    dmem_rdata = '0;
    dmem_ack   = 1'b0;
    model_data = 16'h0000;

    // Reset state, and stall following mem_en while in reset.
    #12;
    check("rst_data_out", data_out, 0);
    check("rst_req", dmem_req, 0);
    check("rst_dmem_we", dmem_we, 0);
    check("rst_dmem_addr", dmem_addr, 0);
    check("rst_dmem_wdata", dmem_wdata, 0);
    check("rst_done", done, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_stall_lo", stall, 0);
    mem_en = 1'b1;
    #1 check("rst_stall_hi", stall, 1);
    mem_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // LW zero-wait, SW with 3-cycle ack at 0xFFFF, back-to-back loads.
    do_op(1'b0, 16'h0010, 16'h0000, 1, 16'hBEEF, 1'b0);
    do_op(1'b1, 16'hFFFF, 16'h1234, 3, 16'hDEAD, 1'b0);
    do_op(1'b0, 16'h5555, 16'h0000, 2, 16'h5555, 1'b0);
    do_op(1'b0, 16'hAAAA, 16'h0000, 1, 16'hAAAA, 1'b0);

    for (int i = 0; i < 6; i++) begin
      do_op(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
            16'($urandom_range(0, 65535)), $urandom_range(1, 5),
            16'($urandom_range(0, 65535)), 1'b0);
    end

    // Reset mid-REQ, then a stray ack.
    mem_en = 1'b1;
    mem_we = 1'b0;
    addr   = 16'h0042;
    @(posedge clk); #1;
    check("mid_req_up", dmem_req, 1);
    #1;
    rst_n  = 1'b0;
    mem_en = 1'b0;
    #1;
    check("mid_rst_req", dmem_req, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_addr", dmem_addr, 0);
    check("mid_rst_done", done, 0);
    model_data = 16'h0000;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n      = 1'b1;
    dmem_ack   = 1'b1;
    dmem_rdata = 16'h7777;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stray_done", done, 0);
      check("stray_req", dmem_req, 0);
      check("stray_data", data_out, 0);
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
    do_op(1'b0, 16'h0100, 16'h0000, 2, 16'hC0DE, 1'b0);
    do_op(1'b0, 16'h0200, 16'h0000, 0, 16'h0000, 1'b1);
    do_op(1'b0, 16'h0300, 16'h0000, TO, 16'h4321, 1'b0);
    do_op(1'b1, 16'h0400, 16'h9999, 0, 16'h0000, 1'b1);
`endif

    do_op(1'b0, 16'h0001, 16'h0000, 1, 16'h0F0F, 1'b0);
    check("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
